// File: rtl/tdc_pulser_pkg.sv
// Shared types and constants for the TDC calibration hit pulser.
// The optional LOW-phase dither (TDC_PULSER_DITHER_EN) uses the LFSR constants below.
package tdc_pulser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_WID_W = 8;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0].
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tdc_hit_pulser_if.sv
// Control/status bundle between the slow-control bank and the hit pulser.
// master = register bank side, slave = pulser side.
interface tdc_hit_pulser_if
    import tdc_pulser_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WID_W = DEF_WID_W
) ();

    logic             start;
    logic             stop;
    logic [CNT_W-1:0] period;
    logic [WID_W-1:0] pulse_width;
    logic [CNT_W-1:0] num_pulses;
    logic             hit_out;
    logic             busy;
    logic             done;
    logic             config_err;
    logic [CNT_W-1:0] pulse_count;

    modport master (
        output start, stop, period, pulse_width, num_pulses,
        input  hit_out, busy, done, config_err, pulse_count
    );

    modport slave (
        input  start, stop, period, pulse_width, num_pulses,
        output hit_out, busy, done, config_err, pulse_count
    );

endinterface

// File: rtl/tdc_lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when enabled; reseeded on rst.
// Used by tdc_hit_pulser only when TDC_PULSER_DITHER_EN is defined.
module tdc_lfsr16
    import tdc_pulser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else if (en) begin
            lfsr_reg <= lfsr_next(lfsr_reg);
        end
    end

    assign state = lfsr_reg;

endmodule

// File: rtl/tdc_hit_pulser.sv
// Programmable calibration hit-pulse train generator for the TDC front end.
// Optional LOW-phase dither is enabled by defining TDC_PULSER_DITHER_EN.
module tdc_hit_pulser
    import tdc_pulser_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WID_W = DEF_WID_W
) (
    input  logic             clk,
    input  logic             rst,
    tdc_hit_pulser_if.slave  bus
);

`ifdef TDC_PULSER_DITHER_EN
    // One spare bit so period - width + 3 can never wrap the phase timer.
    localparam int TMR_W = CNT_W + 1;
`else
    localparam int TMR_W = CNT_W;
`endif

    state_t           state_reg;
    logic [TMR_W-1:0] tmr_reg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] width_reg;
    logic [CNT_W-1:0] num_reg;
    logic [CNT_W-1:0] count_reg;
    logic             stop_seen_reg;
    logic             hit_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic [CNT_W-1:0] width_ext;
    logic             cfg_valid;
    logic             accept;
    logic             low_expire;
    logic             enter_high;
    logic             target_hit;
    logic [CNT_W-1:0] count_next;
    logic [TMR_W-1:0] high_load;
    logic [TMR_W-1:0] low_load;
    logic [1:0]       dither;

    assign width_ext = CNT_W'(bus.pulse_width);
    assign cfg_valid = (bus.pulse_width != '0) && (bus.period > width_ext);

    always_comb begin
        accept     = (state_reg == IDLE) && bus.start && !bus.stop && cfg_valid;
        low_expire = (state_reg == LOW) && !bus.stop && (tmr_reg == '0);
        enter_high = accept || low_expire;
        target_hit = (num_reg != '0) && (count_reg == num_reg);
        if (accept) begin
            count_next = CNT_W'(1);
        end else if (count_reg == '1) begin
            count_next = count_reg;
        end else begin
            count_next = count_reg + CNT_W'(1);
        end
        high_load = TMR_W'(width_reg - CNT_W'(1));
        low_load  = TMR_W'(period_reg - width_reg - CNT_W'(1)) + TMR_W'(dither);
    end

`ifdef TDC_PULSER_DITHER_EN
    logic [15:0] lfsr_state;

    tdc_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (enter_high),
        .state (lfsr_state)
    );

    assign dither = lfsr_state[1:0];
`else
    assign dither = 2'b00;
`endif

    // Outputs are Moore-registered from the current state, so every output
    // lags the state register by one edge (start at N -> hit_out at N+1).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            tmr_reg       <= '0;
            period_reg    <= '0;
            width_reg     <= '0;
            num_reg       <= '0;
            count_reg     <= '0;
            stop_seen_reg <= 1'b0;
            hit_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    hit_reg  <= 1'b0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (accept) begin
                        period_reg    <= bus.period;
                        width_reg     <= width_ext;
                        num_reg       <= bus.num_pulses;
                        tmr_reg       <= TMR_W'(width_ext - CNT_W'(1));
                        stop_seen_reg <= 1'b0;
                        state_reg     <= HIGH;
                    end else if (bus.start && !bus.stop) begin
                        err_reg <= 1'b1;
                    end
                end
                HIGH: begin
                    hit_reg  <= 1'b1;
                    busy_reg <= 1'b1;
                    done_reg <= 1'b0;
                    if (tmr_reg == '0) begin
                        if (target_hit || stop_seen_reg || bus.stop) begin
                            state_reg <= DONE;
                        end else begin
                            tmr_reg   <= low_load;
                            state_reg <= LOW;
                        end
                    end else begin
                        tmr_reg <= tmr_reg - TMR_W'(1);
                        if (bus.stop) begin
                            stop_seen_reg <= 1'b1;
                        end
                    end
                end
                LOW: begin
                    hit_reg  <= 1'b0;
                    busy_reg <= 1'b1;
                    done_reg <= 1'b0;
                    if (bus.stop) begin
                        state_reg <= DONE;
                    end else if (low_expire) begin
                        tmr_reg   <= high_load;
                        state_reg <= HIGH;
                    end else begin
                        tmr_reg <= tmr_reg - TMR_W'(1);
                    end
                end
                DONE: begin
                    hit_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
            if (enter_high) begin
                count_reg <= count_next;
            end
        end
    end

    assign bus.hit_out     = hit_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.config_err  = err_reg;
    assign bus.pulse_count = count_reg;

endmodule
